// File: rtl/lane_change_executor.sv
// Lane-change executor: ramps velocity to a clamped target, then steps lateral position to a clamped lane.
// Optional macro SMOOTH_STEP_EN enables a 2-unit lateral step when the lane is 3 or more units away.
module lane_change_executor #(
   parameter logic [7:0] MAX_VELOCITY = 8'd50,
   parameter logic [7:0] VEL_STEP     = 8'd5,
   parameter logic [7:0] LANE_MAX_X   = 8'd12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cmd_velocity,
   input  logic [7:0] cmd_distancex,
   input  logic [7:0] cmd_distancey,
   input  logic       cmd_enable,
   output logic       cmd_ready,
   output logic [7:0] car_velocity,
   output logic [7:0] car_distancex,
   output logic [7:0] car_distancey,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VEL  = 2'd1,
      ST_LAT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t     state_r, state_next_s;
   logic [7:0] tgt_vel_r, tgt_vel_next_s;
   logic [7:0] tgt_x_r, tgt_x_next_s;
   logic [7:0] vel_r, vel_next_s;
   logic [7:0] x_r, x_next_s;
   logic [7:0] y_r, y_next_s;
   logic [7:0] vel_diff_s, vel_step_s;
   logic [7:0] x_diff_s, x_step_s;

   // Lateral step never exceeds the remaining distance, so the target cannot be overshot.
   function automatic logic [7:0] lat_step(input logic [7:0] diff);
`ifdef SMOOTH_STEP_EN
      if (diff >= 8'd3) begin
         lat_step = 8'd2;
      end else if (diff == 8'd0) begin
         lat_step = 8'd0;
      end else begin
         lat_step = 8'd1;
      end
`else
      if (diff == 8'd0) begin
         lat_step = 8'd0;
      end else begin
         lat_step = 8'd1;
      end
`endif
   endfunction

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         tgt_vel_r <= 8'd0;
         tgt_x_r   <= 8'd0;
         vel_r     <= 8'd0;
         x_r       <= 8'd0;
         y_r       <= 8'd0;
      end else begin
         state_r   <= state_next_s;
         tgt_vel_r <= tgt_vel_next_s;
         tgt_x_r   <= tgt_x_next_s;
         vel_r     <= vel_next_s;
         x_r       <= x_next_s;
         y_r       <= y_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_enable) begin
               state_next_s = ST_VEL;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_VEL: begin
            if (vel_r == tgt_vel_r) begin
               state_next_s = ST_LAT;
            end else begin
               state_next_s = ST_VEL;
            end
         end
         ST_LAT: begin
            if (x_r == tgt_x_r) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_LAT;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bounded step sizes toward the latched targets.
   always_comb begin
      vel_diff_s = (vel_r > tgt_vel_r) ? (vel_r - tgt_vel_r) : (tgt_vel_r - vel_r);
      vel_step_s = (vel_diff_s < VEL_STEP) ? vel_diff_s : VEL_STEP;
      x_diff_s   = (x_r > tgt_x_r) ? (x_r - tgt_x_r) : (tgt_x_r - x_r);
      x_step_s   = lat_step(x_diff_s);
   end

   // Datapath next values; longitudinal position integrates the pre-update velocity.
   always_comb begin
      tgt_vel_next_s = tgt_vel_r;
      tgt_x_next_s   = tgt_x_r;
      vel_next_s     = vel_r;
      x_next_s       = x_r;
      y_next_s       = y_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_enable) begin
               tgt_vel_next_s = (cmd_velocity > MAX_VELOCITY) ? MAX_VELOCITY : cmd_velocity;
               tgt_x_next_s   = (cmd_distancex > LANE_MAX_X) ? LANE_MAX_X : cmd_distancex;
               y_next_s       = cmd_distancey;
            end else begin
               y_next_s = y_r;
            end
         end
         ST_VEL: begin
            y_next_s = y_r + {3'd0, vel_r[7:3]};
            if (vel_r < tgt_vel_r) begin
               vel_next_s = vel_r + vel_step_s;
            end else if (vel_r > tgt_vel_r) begin
               vel_next_s = vel_r - vel_step_s;
            end else begin
               vel_next_s = vel_r;
            end
         end
         ST_LAT: begin
            y_next_s = y_r + {3'd0, vel_r[7:3]};
            if (x_r < tgt_x_r) begin
               x_next_s = x_r + x_step_s;
            end else if (x_r > tgt_x_r) begin
               x_next_s = x_r - x_step_s;
            end else begin
               x_next_s = x_r;
            end
         end
         ST_DONE: y_next_s = y_r;
         default: y_next_s = y_r;
      endcase
   end

   // Status decode from the registered state.
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_r)
         ST_IDLE: cmd_ready = 1'b1;
         ST_VEL:  busy = 1'b1;
         ST_LAT:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign car_velocity  = vel_r;
   assign car_distancex = x_r;
   assign car_distancey = y_r;

endmodule

// File: tb/tb_lane_change_executor.sv
// Directed self-checking bench for lane_change_executor; follows SMOOTH_STEP_EN when it is defined.
module tb_lane_change_executor;

   logic       clock;
   logic       reset;
   logic [7:0] cmd_velocity;
   logic [7:0] cmd_distancex;
   logic [7:0] cmd_distancey;
   logic       cmd_enable;
   logic       cmd_ready;
   logic [7:0] car_velocity;
   logic [7:0] car_distancex;
   logic [7:0] car_distancey;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   lane_change_executor dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_velocity (cmd_velocity),
      .cmd_distancex(cmd_distancex),
      .cmd_distancey(cmd_distancey),
      .cmd_enable   (cmd_enable),
      .cmd_ready    (cmd_ready),
      .car_velocity (car_velocity),
      .car_distancex(car_distancex),
      .car_distancey(car_distancey),
      .busy         (busy),
      .done         (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      logic [28:0] got;
      reset = 1'b0;
      cmd_enable = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         cmd_velocity  = 8'($urandom);
         cmd_distancex = 8'($urandom);
         cmd_distancey = 8'($urandom);
         cmd_enable    = (i == 1) ? 1'b1 : 1'($urandom);
         tick();
         got = {cmd_ready, busy, done, car_velocity, car_distancex, car_distancey, 2'b00};
         checks++;
         if (got !== {1'b1, 1'b0, 1'b0, 24'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", got, {1'b1, 1'b0, 1'b0, 24'd0, 2'b00});
         end
      end
      cmd_enable = 1'b0;
      #2 reset = 1'b1;
   endtask

   task automatic test_ramp;
      logic [7:0] exp_x[$];
      logic [7:0] exp_y;
`ifdef SMOOTH_STEP_EN
      exp_x = '{8'd2, 8'd4, 8'd5};
      exp_y = 8'd58;
`else
      exp_x = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      exp_y = 8'd70;
`endif
      cmd_velocity = 8'd50; cmd_distancex = 8'd5; cmd_distancey = 8'd4; cmd_enable = 1'b1;
      tick();
      cmd_enable = 1'b0;
      checks++;
      if ({busy, cmd_ready, car_velocity, car_distancey} !== {1'b1, 1'b0, 8'd0, 8'd4}) begin
         errors++;
         $display("FAIL ramp_accept got busy=%b rdy=%b v=%0d y=%0d exp busy=1 rdy=0 v=0 y=4",
                  busy, cmd_ready, car_velocity, car_distancey);
      end
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (car_velocity !== 8'(5 * i)) begin
            errors++;
            $display("FAIL ramp_vel step=%0d got=%0d exp=%0d", i, car_velocity, 5 * i);
         end
      end
      tick();
      checks++;
      if ({busy, car_velocity, car_distancex} !== {1'b1, 8'd50, 8'd0}) begin
         errors++;
         $display("FAIL ramp_to_lat got busy=%b v=%0d x=%0d exp busy=1 v=50 x=0", busy, car_velocity, car_distancex);
      end
      foreach (exp_x[k]) begin
         tick();
         checks++;
         if ({busy, done, car_distancex} !== {1'b1, 1'b0, exp_x[k]}) begin
            errors++;
            $display("FAIL ramp_lat k=%0d got busy=%b done=%b x=%0d exp busy=1 done=0 x=%0d",
                     k, busy, done, car_distancex, exp_x[k]);
         end
      end
      tick();
      checks++;
      if ({done, busy, car_distancex, car_distancey} !== {1'b1, 1'b0, 8'd5, exp_y}) begin
         errors++;
         $display("FAIL ramp_done got done=%b busy=%b x=%0d y=%0d exp done=1 busy=0 x=5 y=%0d",
                  done, busy, car_distancex, car_distancey, exp_y);
      end
      tick();
      checks++;
      if ({done, cmd_ready, car_distancey} !== {1'b0, 1'b1, exp_y}) begin
         errors++;
         $display("FAIL ramp_idle got done=%b rdy=%b y=%0d exp done=0 rdy=1 y=%0d", done, cmd_ready, car_distancey, exp_y);
      end
   endtask

   task automatic test_ignore_busy;
      logic [7:0] exp_x[$];
      logic [7:0] exp_y;
`ifdef SMOOTH_STEP_EN
      exp_x = '{8'd3, 8'd2, 8'd1};
      exp_y = 8'd36;
`else
      exp_x = '{8'd4, 8'd3, 8'd2, 8'd1};
      exp_y = 8'd38;
`endif
      cmd_velocity = 8'd20; cmd_distancex = 8'd1; cmd_distancey = 8'd0; cmd_enable = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            cmd_enable = 1'b1; cmd_velocity = 8'd0; cmd_distancex = 8'd0; cmd_distancey = 8'd200;
         end else begin
            cmd_enable = 1'b0;
         end
         tick();
         checks++;
         if (car_velocity !== 8'(45 - 5 * i)) begin
            errors++;
            $display("FAIL down_vel step=%0d got=%0d exp=%0d", i, car_velocity, 45 - 5 * i);
         end
      end
      cmd_enable = 1'b1;
      tick();
      foreach (exp_x[k]) begin
         cmd_enable = (k == 0) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if ({busy, car_velocity, car_distancex} !== {1'b1, 8'd20, exp_x[k]}) begin
            errors++;
            $display("FAIL down_lat k=%0d got busy=%b v=%0d x=%0d exp busy=1 v=20 x=%0d",
                     k, busy, car_velocity, car_distancex, exp_x[k]);
         end
      end
      cmd_enable = 1'b0;
      tick();
      checks++;
      if ({done, car_velocity, car_distancex, car_distancey} !== {1'b1, 8'd20, 8'd1, exp_y}) begin
         errors++;
         $display("FAIL down_done got done=%b v=%0d x=%0d y=%0d exp done=1 v=20 x=1 y=%0d",
                  done, car_velocity, car_distancex, car_distancey, exp_y);
      end
      tick();
   endtask

   task automatic test_saturate;
      int         done_count;
      logic [7:0] max_v, max_x, v_at_done, x_at_done;
      done_count = 0; max_v = 8'd0; max_x = 8'd0; v_at_done = 8'd0; x_at_done = 8'd0;
      cmd_velocity = 8'd80; cmd_distancex = 8'd20; cmd_distancey = 8'd0; cmd_enable = 1'b1;
      tick();
      cmd_enable = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (car_velocity > max_v) max_v = car_velocity;
         if (car_distancex > max_x) max_x = car_distancex;
         if (done) begin
            done_count++;
            v_at_done = car_velocity;
            x_at_done = car_distancex;
         end
      end
      checks++;
      if (done_count !== 1) begin
         errors++;
         $display("FAIL sat_done_count got=%0d exp=1", done_count);
      end
      checks++;
      if ({v_at_done, x_at_done} !== {8'd50, 8'd12}) begin
         errors++;
         $display("FAIL sat_final got v=%0d x=%0d exp v=50 x=12", v_at_done, x_at_done);
      end
      checks++;
      if ({max_v, max_x, cmd_ready} !== {8'd50, 8'd12, 1'b1}) begin
         errors++;
         $display("FAIL sat_overshoot got maxv=%0d maxx=%0d rdy=%b exp 50 12 1", max_v, max_x, cmd_ready);
      end
   endtask

   task automatic test_exact_match;
      cmd_velocity = 8'd50; cmd_distancex = 8'd12; cmd_distancey = 8'd7; cmd_enable = 1'b1;
      tick();
      cmd_enable = 1'b0;
      checks++;
      if ({busy, car_distancey} !== {1'b1, 8'd7}) begin
         errors++;
         $display("FAIL exact_accept got busy=%b y=%0d exp busy=1 y=7", busy, car_distancey);
      end
      tick();
      checks++;
      if ({busy, done, car_velocity, car_distancey} !== {1'b1, 1'b0, 8'd50, 8'd13}) begin
         errors++;
         $display("FAIL exact_lat got busy=%b done=%b v=%0d y=%0d exp 1 0 50 13", busy, done, car_velocity, car_distancey);
      end
      tick();
      checks++;
      if ({done, car_distancex, car_distancey} !== {1'b1, 8'd12, 8'd19}) begin
         errors++;
         $display("FAIL exact_done got done=%b x=%0d y=%0d exp 1 12 19", done, car_distancex, car_distancey);
      end
      tick();
   endtask

   task automatic test_start_y;
      reset = 1'b0;
      #2 reset = 1'b1;
      checks++;
      if ({cmd_ready, car_velocity, car_distancex, car_distancey} !== {1'b1, 24'd0}) begin
         errors++;
         $display("FAIL y_reset got rdy=%b v=%0d x=%0d y=%0d exp 1 0 0 0", cmd_ready, car_velocity, car_distancex, car_distancey);
      end
      cmd_velocity = 8'd10; cmd_distancex = 8'd0; cmd_distancey = 8'd100; cmd_enable = 1'b1;
      tick();
      cmd_enable = 1'b0;
      checks++;
      if ({busy, car_distancey} !== {1'b1, 8'd100}) begin
         errors++;
         $display("FAIL y_first_accept got busy=%b y=%0d exp busy=1 y=100", busy, car_distancey);
      end
      tick();
      tick();
      checks++;
      if (car_velocity !== 8'd10) begin
         errors++;
         $display("FAIL y_vel got=%0d exp=10", car_velocity);
      end
      tick();
      checks++;
      if ({busy, car_distancey} !== {1'b1, 8'd101}) begin
         errors++;
         $display("FAIL y_lat got busy=%b y=%0d exp busy=1 y=101", busy, car_distancey);
      end
      tick();
      checks++;
      if ({done, car_distancex, car_distancey} !== {1'b1, 8'd0, 8'd102}) begin
         errors++;
         $display("FAIL y_done got done=%b x=%0d y=%0d exp 1 0 102", done, car_distancex, car_distancey);
      end
      tick();
      checks++;
      if ({cmd_ready, car_distancey} !== {1'b1, 8'd102}) begin
         errors++;
         $display("FAIL y_hold got rdy=%b y=%0d exp 1 102", cmd_ready, car_distancey);
      end
   endtask

   task automatic test_reset_mid_lat;
      logic seen_done;
      seen_done = 1'b0;
      cmd_velocity = 8'd5; cmd_distancex = 8'd3; cmd_distancey = 8'd9; cmd_enable = 1'b1;
      tick();
      cmd_enable = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({busy, car_velocity} !== {1'b1, 8'd5} || car_distancex == 8'd0) begin
         errors++;
         $display("FAIL mid_lat_setup got busy=%b v=%0d x=%0d exp busy=1 v=5 x>0", busy, car_velocity, car_distancex);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done, car_velocity, car_distancex, car_distancey} !== {1'b1, 2'b00, 24'd0}) begin
         errors++;
         $display("FAIL mid_lat_abort got rdy=%b busy=%b done=%b v=%0d x=%0d y=%0d exp 1 0 0 0 0 0",
                  cmd_ready, busy, done, car_velocity, car_distancex, car_distancey);
      end
      tick();
      #2 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      checks++;
      if ({seen_done, cmd_ready} !== 2'b01) begin
         errors++;
         $display("FAIL mid_lat_no_done got done_seen=%b rdy=%b exp 0 1", seen_done, cmd_ready);
      end
   endtask

   initial begin
      reset = 1'b0;
      cmd_velocity = 8'd0; cmd_distancex = 8'd0; cmd_distancey = 8'd0; cmd_enable = 1'b0;
      test_reset();
      test_ramp();
      test_ignore_busy();
      test_saturate();
      test_exact_match();
      test_start_y();
      test_reset_mid_lat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
